// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide execute unit: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [XLEN-1:0] fix_x(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] fix_2x(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic            a_neg_q, b_neg_q;
  logic [XLEN-1:0] mag_a_q, mag_b_q;
  logic [XLEN-1:0] hi_q, lo_q;

  // Request decode: signedness, magnitudes and the fast-path cases
  logic            sa_in, sb_in, a_neg, b_neg, b_zero, ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign sa_in  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sb_in  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg  = sa_in & op_a[XLEN-1];
  assign b_neg  = sb_in & op_b[XLEN-1];
  assign a_mag  = fix_x(op_a, a_neg);
  assign b_mag  = fix_x(op_b, b_neg);
  assign b_zero = (op_b == '0);
  assign ovf    = sb_in && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     ax, bx;
  logic signed [2*XLEN-1:0] pf;
  assign ax = {sa_in & op_a[XLEN-1], op_a};
  assign bx = {sb_in & op_b[XLEN-1], op_b};
  assign pf = (2*XLEN)'(ax) * (2*XLEN)'(bx);
  assign fast = ~funct3[2] | b_zero | ovf;
  always_comb begin
    fast_res = '0;
    if (!funct3[2])   fast_res = (funct3[1:0] == 2'b00) ? pf[XLEN-1:0] : pf[2*XLEN-1:XLEN];
    else if (b_zero)  fast_res = funct3[1] ? op_a : '1;
    else              fast_res = funct3[1] ? '0 : op_a;
  end
`else
  assign fast = funct3[2] & (b_zero | ovf);
  always_comb begin
    fast_res = '0;
    if (b_zero) fast_res = funct3[1] ? op_a : '1;
    else        fast_res = funct3[1] ? '0 : op_a;
  end
`endif

  // One iteration step: shift-add multiply or restoring divide on {hi_q, lo_q}
  logic [XLEN:0]     sum;
  logic [XLEN:0]     part;
  logic              ge;
  logic [XLEN-1:0]   diff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   final_res;

  assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
  assign part = {hi_q, lo_q[XLEN-1]};
  assign ge   = part >= {1'b0, mag_b_q};
  assign diff = part[XLEN-1:0] - mag_b_q;

  always_comb begin
    if (f3_q[2]) begin
      step_hi = ge ? diff : part[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], ge};
    end else begin
      step_hi = sum[XLEN:1];
      step_lo = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod_f = fix_2x({step_hi, step_lo}, a_neg_q ^ b_neg_q);

  always_comb begin
    case (f3_q)
      3'b000:          final_res = prod_f[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          final_res = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:  final_res = fix_x(step_lo, a_neg_q ^ b_neg_q);
      default:         final_res = fix_x(step_hi, a_neg_q);
    endcase
  end

  assign busy = (state != IDLE);

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid) begin
            out_tag  <= in_tag;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (fast) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= fast_res;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= final_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Operand capture at accept, then one step per ITER cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      f3_q    <= funct3;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      mag_a_q <= a_mag;
      mag_b_q <= b_mag;
      hi_q    <= '0;
      lo_q    <= funct3[2] ? a_mag : b_mag;
    end else if (state == ITER) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32, TAG_W=5.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic        busy;

  int ncmp = 0;
  int nerr = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, count edges from the accept edge until out_valid, track in_ready while waiting
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output int lat, output logic [31:0] r,
                       output logic [4:0] ot, output logic ir_low);
    funct3 = f; op_a = a; op_b = b; in_tag = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = 32'h5A5A_1234; op_b = 32'h0000_0003; in_tag = 5'h1F;
    lat = 1;
    ir_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) ir_low = 1'b0;
      tick();
      lat++;
    end
    if (in_ready !== 1'b0) ir_low = 1'b0;
    r = result;
    ot = out_tag;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    ncmp++;
    if ({out_valid, busy, in_ready, out_tag, result} !== '0) begin
      $display("FAIL reset_outputs: got ov=%b busy=%b ir=%b tag=%h res=%h want all 0",
               out_valid, busy, in_ready, out_tag, result);
      nerr++;
    end
    reset = 1'b0;
    tick();
    ncmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release: got ir=%b busy=%b want ir=1 busy=0", in_ready, busy);
      nerr++;
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f  [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] a  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int lat; logic [31:0] r; logic [4:0] ot; logic irl;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'(5 + i), lat, r, ot, irl);
      ncmp++;
      if (r !== ex[i] || ot !== 5'(5 + i)) begin
        $display("FAIL mul_%0d: got res=%h tag=%0d want res=%h tag=%0d", i, r, ot, ex[i], 5 + i);
        nerr++;
      end
      ncmp++;
      if (lat !== MUL_LAT) begin
        $display("FAIL mul_lat_%0d: got %0d edges want %0d", i, lat, MUL_LAT);
        nerr++;
      end
      retire();
    end
  endtask

  task automatic test_div();
    logic [2:0]  f  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a  [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100};
    logic [31:0] b  [4] = '{32'd3, 32'd3, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd14, 32'd2};
    int lat; logic [31:0] r; logic [4:0] ot; logic irl;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'(20 + i), lat, r, ot, irl);
      ncmp++;
      if (r !== ex[i] || ot !== 5'(20 + i)) begin
        $display("FAIL div_%0d: got res=%h tag=%0d want res=%h tag=%0d", i, r, ot, ex[i], 20 + i);
        nerr++;
      end
      ncmp++;
      if (lat !== 33 || irl !== 1'b1) begin
        $display("FAIL div_lat_%0d: got lat=%0d ready_low=%b want lat=33 ready_low=1", i, lat, irl);
        nerr++;
      end
      retire();
    end
  endtask

  task automatic test_div_corner();
    logic [2:0]  f  [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] a  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat; logic [31:0] r; logic [4:0] ot; logic irl;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'(10 + i), lat, r, ot, irl);
      ncmp++;
      if (r !== ex[i] || lat !== 1 || ot !== 5'(10 + i)) begin
        $display("FAIL div_corner_%0d: got res=%h lat=%0d tag=%0d want res=%h lat=1 tag=%0d",
                 i, r, lat, ot, ex[i], 10 + i);
        nerr++;
      end
      retire();
    end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] r; logic [4:0] ot; logic irl;
    issue(3'b101, 32'd100, 32'd7, 5'd9, lat, r, ot, irl);
    for (int i = 0; i < 10; i++) begin
      tick();
      ncmp++;
      if (out_valid !== 1'b1 || result !== 32'd14 || out_tag !== 5'd9 || in_ready !== 1'b0) begin
        $display("FAIL hold_%0d: got ov=%b res=%h tag=%0d ir=%b want ov=1 res=0000000e tag=9 ir=0",
                 i, out_valid, result, out_tag, in_ready);
        nerr++;
      end
    end
    retire();
    ncmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
      $display("FAIL hold_retire: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0", out_valid, in_ready, result);
      nerr++;
    end
  endtask

  task automatic test_flush();
    logic seen;
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; in_tag = 5'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    ncmp++;
    if (busy !== 1'b1) begin
      $display("FAIL flush_pre: got busy=%b want 1", busy);
      nerr++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ncmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_abort: got busy=%b ov=%b ir=%b want busy=0 ov=0 ir=1", busy, out_valid, in_ready);
      nerr++;
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    ncmp++;
    if (seen !== 1'b0) begin
      $display("FAIL flush_no_output: got out_valid pulse=%b want 0", seen);
      nerr++;
    end
  endtask

  task automatic test_reset_mid();
    funct3 = 3'b100; op_a = 32'hFFFF_FFEC; op_b = 32'd3; in_tag = 5'd17; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    ncmp++;
    if ({out_valid, busy, in_ready, out_tag, result} !== '0) begin
      $display("FAIL reset_mid: got ov=%b busy=%b ir=%b tag=%h res=%h want all 0",
               out_valid, busy, in_ready, out_tag, result);
      nerr++;
    end
    reset = 1'b0;
    tick();
    ncmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_mid_release: got ir=%b want 1", in_ready);
      nerr++;
    end
  endtask

  task automatic test_flush_accept();
    logic seen;
    funct3 = 3'b100; op_a = 32'd5; op_b = 32'd0; in_tag = 5'd2;
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    ncmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_accept: got busy=%b ov=%b ir=%b want busy=0 ov=0 ir=1", busy, out_valid, in_ready);
      nerr++;
    end
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    ncmp++;
    if (seen !== 1'b0) begin
      $display("FAIL flush_accept_idle: got activity=%b want 0", seen);
      nerr++;
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r; logic [4:0] ot; logic irl;
    issue(3'b110, 32'd100, 32'd7, 5'd30, lat, r, ot, irl);
    retire();
    issue(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd31, lat, r, ot, irl);
    ncmp++;
    if (r !== 32'hFFFF_FFF2 || ot !== 5'd31 || lat !== 33) begin
      $display("FAIL back_to_back: got res=%h tag=%0d lat=%0d want res=fffffff2 tag=31 lat=33", r, ot, lat);
      nerr++;
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_corner();
    test_hold();
    test_flush();
    test_reset_mid();
    test_flush_accept();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
